pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register that generalises the fixed inter-stage latches into a valid/ready handshake stage.
- Carries PC, instruction and a DATA_W-bit payload between any two CPU stages.
- Optional one-entry skid buffer breaks the combinational ready path; flush inserts a bubble (NOP).
- Includes a saturating back-pressure (stall) cycle counter for performance debug.

Parameters:
- DATA_W, 64, width of the generic payload (ALU result, DM data, control bits packed by the instantiating stage).
- PC_RESET, 32'h0000_3000, value loaded into out_pc on reset and flush.
- SKID_EN, 1, 1 = two-entry stage (main + skid, registered in_ready); 0 = single-entry stage (in_ready combinational).
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  discard all held entries, emit a bubble.
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  32  upstream PC.
- in_instr  in  32  upstream instruction.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_* hold a valid entry.
- out_ready  in  1  downstream accepts this cycle.
- out_pc  out  32  registered PC.
- out_instr  out  32  registered instruction; 0 (NOP) when bubble.
- out_data  out  DATA_W  registered payload.
- clr_cnt  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Definitions: acc = in_valid & in_ready; pop = out_valid & out_ready.
- Reset (reset=0, async): state EMPTY, out_valid=0, out_pc=PC_RESET, out_instr=0, out_data=0, skid regs 0, stall_cnt=0, in_ready=1. Values are held while reset is asserted. Reset mid-transfer drops all entries.
- State (SKID_EN=1): EMPTY (0 entries), ONE (main full), FULL (main + skid). in_ready = (state != FULL), decoded from the state register only; no out_ready→in_ready path.
- Transitions, evaluated at each clk edge in priority order:
  - flush=1: →EMPTY; out_valid←0, out_pc←PC_RESET, out_instr←0, out_data←0. Any acc in the same cycle is dropped; upstream treats it as consumed.
  - EMPTY, acc: main←in, →ONE.
  - ONE, acc & pop: main←in, stay ONE.
  - ONE, acc & !pop: skid←in, →FULL.
  - ONE, !acc & pop: →EMPTY.
  - FULL, pop: main←skid, →ONE (acc impossible).
  - Otherwise hold.
- out_valid = (state != EMPTY). out_* are always driven from the main register.
- Ordering: strict FIFO; no entry is lost or duplicated except on flush or reset.
- Latency: 1 cycle from acc to out_valid when EMPTY. Throughput: 1 entry/cycle with out_ready held high.
- SKID_EN=0: FULL state unused. in_ready = !out_valid | out_ready (combinational). acc loads main; pop without acc →EMPTY. flush rules are unchanged.
- When out_valid=0, out_* hold their last loaded value (or the reset/flush value). Downstream must qualify with out_valid.
- stall_cnt:
  - +1 each cycle with out_valid & !out_ready; saturates at 2^CNT_W−1 (no wrap).
  - clr_cnt=1 forces 0 and has priority over increment.
  - flush does not clear it.
- Simultaneous flush & clr_cnt: both take effect.

Test Plan:
- Reset then release; check out_valid=0, out_pc=32'h0000_3000, out_instr=0, in_ready=1, stall_cnt=0. Then push pc=0x3004, instr=0x8C010004 with out_ready=1 → next cycle out_valid=1 with the same values.
- Streaming, SKID_EN=1: push 8 entries back-to-back with out_ready=1 → 8 consecutive pops in order, in_ready stays 1, stall_cnt=0.
- Back-pressure: out_ready=0, push A,B,C → in_ready drops after B (FULL), C held upstream, stall_cnt increments each cycle. Raise out_ready → pops A,B,C in order.
- Flush while FULL with in_valid=1 → next cycle out_valid=0, out_instr=0, out_pc=0x3000, in_ready=1; the entry offered in the flush cycle never appears.
- Saturation: CNT_W=4, hold out_valid=1/out_ready=0 for 20 cycles → stall_cnt=15. Pulse clr_cnt → 0 next cycle.
- SKID_EN=0: out_ready=0 with one entry held → in_ready=0. Set out_ready=1 and in_valid=1 in the same cycle → in_ready=1 combinationally, the new entry replaces the popped one, and out_valid stays 1.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage carrying PC, instruction and a generic payload,
// with an optional skid entry, flush-to-bubble and a saturating stall counter.
module pipe_stage_buf #(
    parameter int          DATA_W   = 64,
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          SKID_EN  = 1,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [DATA_W-1:0] out_data,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state_reg;
    state_t              state_next;
    logic                acc;
    logic                pop;
    logic                load_main_in;
    logic                load_main_skid;
    logic                load_skid;

    logic [31:0]         main_pc_reg;
    logic [31:0]         main_instr_reg;
    logic [DATA_W-1:0]   main_data_reg;
    logic [31:0]         skid_pc_reg;
    logic [31:0]         skid_instr_reg;
    logic [DATA_W-1:0]   skid_data_reg;
    logic [CNT_W-1:0]    stall_cnt_reg;

    assign out_valid = (state_reg != EMPTY);
    assign pop       = out_valid & out_ready;
    assign acc       = in_valid & in_ready;

    // With the skid entry, in_ready comes from the state register only so the
    // downstream ready never reaches upstream combinationally.
    generate
        if (SKID_EN != 0) begin : g_skid
            assign in_ready = (state_reg != FULL);
        end else begin : g_noskid
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (acc) begin
                        load_main_in = 1'b1;
                        state_next   = ONE;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        load_main_in = 1'b1;
                    end else if (acc && (SKID_EN != 0)) begin
                        load_skid  = 1'b1;
                        state_next = FULL;
                    end else if (!acc && pop) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        load_main_skid = 1'b1;
                        state_next     = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= EMPTY;
            main_pc_reg    <= PC_RESET;
            main_instr_reg <= 32'h0;
            main_data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (flush) begin
                main_pc_reg    <= PC_RESET;
                main_instr_reg <= 32'h0;
                main_data_reg  <= '0;
            end else if (load_main_in) begin
                main_pc_reg    <= in_pc;
                main_instr_reg <= in_instr;
                main_data_reg  <= in_data;
            end else if (load_main_skid) begin
                main_pc_reg    <= skid_pc_reg;
                main_instr_reg <= skid_instr_reg;
                main_data_reg  <= skid_data_reg;
            end
        end
    end

    // Skid contents are don't-care once flushed; state alone marks them stale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_pc_reg    <= 32'h0;
            skid_instr_reg <= 32'h0;
            skid_data_reg  <= '0;
        end else if (load_skid) begin
            skid_pc_reg    <= in_pc;
            skid_instr_reg <= in_instr;
            skid_data_reg  <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
        end else if (clr_cnt) begin
            stall_cnt_reg <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_reg != CNT_MAX)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
        end
    end

    assign out_pc    = main_pc_reg;
    assign out_instr = main_instr_reg;
    assign out_data  = main_data_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench: a skid stage (CNT_W=4) and a single-entry stage, driven by
// directed vectors; accepted entries are queued and checked when popped.
module tb_pipe_stage_buf;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [63:0] data;
    } ent_t;

    logic clk;
    logic reset;

    logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0, clr0;
    logic [31:0] in_pc0, in_instr0, out_pc0, out_instr0;
    logic [63:0] in_data0, out_data0;
    logic [3:0]  stall0;

    logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1, clr1;
    logic [31:0] in_pc1, in_instr1, out_pc1, out_instr1;
    logic [63:0] in_data1, out_data1;
    logic [15:0] stall1;

    ent_t sb0[$];
    ent_t sb1[$];
    int   checks = 0;
    int   errors = 0;
    int   pops0  = 0;
    int   pops1  = 0;

    pipe_stage_buf #(.DATA_W(64), .PC_RESET(32'h0000_3000), .SKID_EN(1), .CNT_W(4)) u_skid (
        .clk(clk), .reset(reset), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .in_pc(in_pc0), .in_instr(in_instr0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_pc(out_pc0), .out_instr(out_instr0), .out_data(out_data0),
        .clr_cnt(clr0), .stall_cnt(stall0)
    );

    pipe_stage_buf #(.DATA_W(64), .PC_RESET(32'h0000_3000), .SKID_EN(0), .CNT_W(16)) u_noskid (
        .clk(clk), .reset(reset), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_pc(in_pc1), .in_instr(in_instr1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_pc(out_pc1), .out_instr(out_instr1), .out_data(out_data1),
        .clr_cnt(clr1), .stall_cnt(stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic [63:0] data);
        ent_t e;
        e.pc    = pc;
        e.instr = instr;
        e.data  = data;
        return e;
    endfunction

    // One clock of stimulus on the selected stage; returns in_ready seen mid-cycle.
    task automatic cyc(input int sel, input logic v, input ent_t e, input logic ordy,
                       input logic fl, input logic clr, output logic rdy);
        in_valid0 = (sel == 0) && v;  flush0 = (sel == 0) && fl;  clr0 = (sel == 0) && clr;
        in_valid1 = (sel == 1) && v;  flush1 = (sel == 1) && fl;  clr1 = (sel == 1) && clr;
        in_pc0 = e.pc;  in_instr0 = e.instr;  in_data0 = e.data;
        in_pc1 = e.pc;  in_instr1 = e.instr;  in_data1 = e.data;
        if (sel == 0) out_ready0 = ordy; else out_ready1 = ordy;
        @(negedge clk);
        rdy = (sel == 0) ? in_ready0 : in_ready1;
        if (fl) begin
            if (sel == 0) sb0.delete(); else sb1.delete();
        end else if (v && rdy) begin
            if (sel == 0) sb0.push_back(e); else sb1.push_back(e);
            $display("push%0d pc=%h instr=%h data=%h", sel, e.pc, e.instr, e.data);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset && out_valid0 && out_ready0 && !flush0) begin
            pops0++;
            $display("pop0 pc=%h instr=%h data=%h", out_pc0, out_instr0, out_data0);
            if (sb0.size() == 0) begin
                chk("pop0_underflow", 64'(sb0.size()), 64'd1);
            end else begin
                ent_t e;
                e = sb0.pop_front();
                chk("pop0_pc", {32'h0, out_pc0}, {32'h0, e.pc});
                chk("pop0_instr", {32'h0, out_instr0}, {32'h0, e.instr});
                chk("pop0_data", out_data0, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (reset && out_valid1 && out_ready1 && !flush1) begin
            pops1++;
            $display("pop1 pc=%h instr=%h data=%h", out_pc1, out_instr1, out_data1);
            if (sb1.size() == 0) begin
                chk("pop1_underflow", 64'(sb1.size()), 64'd1);
            end else begin
                ent_t e;
                e = sb1.pop_front();
                chk("pop1_pc", {32'h0, out_pc1}, {32'h0, e.pc});
                chk("pop1_instr", {32'h0, out_instr1}, {32'h0, e.instr});
                chk("pop1_data", out_data1, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rdy;
        ent_t nil;
        nil = mk(32'h0, 32'h0, 64'h0);
        reset = 1'b0;
        {flush0, in_valid0, out_ready0, clr0, flush1, in_valid1, out_ready1, clr1} = '0;
        {in_pc0, in_instr0, in_pc1, in_instr1} = '0;
        in_data0 = '0;
        in_data1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'h0, out_valid0}, 64'd0);
        chk("rst_out_pc", {32'h0, out_pc0}, 64'h3000);
        chk("rst_out_instr", {32'h0, out_instr0}, 64'd0);
        chk("rst_out_data", out_data0, 64'd0);
        chk("rst_in_ready", {63'h0, in_ready0}, 64'd1);
        chk("rst_stall_cnt", {60'h0, stall0}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // First entry: visible one cycle after acceptance.
        cyc(0, 1'b1, mk(32'h3004, 32'h8C01_0004, 64'h1111), 1'b1, 1'b0, 1'b0, rdy);
        chk("first_out_valid", {63'h0, out_valid0}, 64'd1);
        chk("first_out_pc", {32'h0, out_pc0}, 64'h3004);
        chk("first_out_instr", {32'h0, out_instr0}, 64'h8C01_0004);

        // Streaming: eight back-to-back entries with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1'b1, mk(32'h3008 + 32'(4 * i), 32'h0100_0000 + 32'(i), 64'hA000 + 64'(i)),
                1'b1, 1'b0, 1'b0, rdy);
            chk("stream_in_ready", {63'h0, rdy}, 64'd1);
        end
        cyc(0, 1'b0, nil, 1'b1, 1'b0, 1'b0, rdy);
        chk("stream_stall_cnt", {60'h0, stall0}, 64'd0);
        chk("stream_drained", {63'h0, out_valid0}, 64'd0);

        // Back-pressure: A, B fill main+skid, C is held off until space frees.
        cyc(0, 1'b1, mk(32'h4000, 32'hAAAA_0001, 64'hA), 1'b0, 1'b0, 1'b0, rdy);
        chk("bp_ready_a", {63'h0, rdy}, 64'd1);
        cyc(0, 1'b1, mk(32'h4004, 32'hBBBB_0002, 64'hB), 1'b0, 1'b0, 1'b0, rdy);
        chk("bp_ready_b", {63'h0, rdy}, 64'd1);
        cyc(0, 1'b1, mk(32'h4008, 32'hCCCC_0003, 64'hC), 1'b0, 1'b0, 1'b0, rdy);
        chk("bp_ready_c1", {63'h0, rdy}, 64'd0);
        cyc(0, 1'b1, mk(32'h4008, 32'hCCCC_0003, 64'hC), 1'b0, 1'b0, 1'b0, rdy);
        chk("bp_ready_c2", {63'h0, rdy}, 64'd0);
        chk("bp_stall_cnt", {60'h0, stall0}, 64'd3);
        cyc(0, 1'b1, mk(32'h4008, 32'hCCCC_0003, 64'hC), 1'b1, 1'b0, 1'b0, rdy);
        chk("bp_ready_full_pop", {63'h0, rdy}, 64'd0);
        cyc(0, 1'b1, mk(32'h4008, 32'hCCCC_0003, 64'hC), 1'b1, 1'b0, 1'b0, rdy);
        chk("bp_ready_c3", {63'h0, rdy}, 64'd1);
        cyc(0, 1'b0, nil, 1'b1, 1'b0, 1'b0, rdy);
        chk("bp_stall_hold", {60'h0, stall0}, 64'd3);

        // Saturation at 15 with CNT_W=4, then clear.
        cyc(0, 1'b1, mk(32'h5000, 32'hDDDD_0004, 64'hD), 1'b0, 1'b0, 1'b1, rdy);
        chk("sat_cleared", {60'h0, stall0}, 64'd0);
        repeat (15) cyc(0, 1'b0, nil, 1'b0, 1'b0, 1'b0, rdy);
        chk("sat_at_15", {60'h0, stall0}, 64'd15);
        repeat (5) cyc(0, 1'b0, nil, 1'b0, 1'b0, 1'b0, rdy);
        chk("sat_no_wrap", {60'h0, stall0}, 64'd15);
        cyc(0, 1'b0, nil, 1'b0, 1'b0, 1'b1, rdy);
        chk("clr_to_zero", {60'h0, stall0}, 64'd0);

        // Flush while FULL with an entry offered.
        cyc(0, 1'b1, mk(32'h5004, 32'hEEEE_0005, 64'hE), 1'b0, 1'b0, 1'b0, rdy);
        chk("fill_ready_e", {63'h0, rdy}, 64'd1);
        cyc(0, 1'b1, mk(32'h5008, 32'hFFFF_0006, 64'hF), 1'b0, 1'b1, 1'b0, rdy);
        chk("flush_full_ready", {63'h0, rdy}, 64'd0);
        chk("flush_out_valid", {63'h0, out_valid0}, 64'd0);
        chk("flush_out_instr", {32'h0, out_instr0}, 64'd0);
        chk("flush_out_pc", {32'h0, out_pc0}, 64'h3000);
        chk("flush_out_data", out_data0, 64'd0);
        chk("flush_in_ready", {63'h0, in_ready0}, 64'd1);
        chk("flush_keeps_cnt", {60'h0, stall0}, 64'd2);

        // Flush and clr_cnt together, with an accepted entry that must be dropped.
        cyc(0, 1'b1, mk(32'h6000, 32'h1234_0007, 64'h7), 1'b0, 1'b0, 1'b0, rdy);
        cyc(0, 1'b1, mk(32'h6004, 32'h1234_0008, 64'h8), 1'b0, 1'b1, 1'b1, rdy);
        chk("flush_acc_ready", {63'h0, rdy}, 64'd1);
        chk("flush_clr_valid", {63'h0, out_valid0}, 64'd0);
        chk("flush_clr_cnt", {60'h0, stall0}, 64'd0);
        repeat (2) cyc(0, 1'b0, nil, 1'b1, 1'b0, 1'b0, rdy);
        chk("flush_dropped", {63'h0, out_valid0}, 64'd0);

        // Single-entry stage: combinational in_ready and replace-on-pop.
        cyc(1, 1'b1, mk(32'h7000, 32'h0000_0A01, 64'h71), 1'b0, 1'b0, 1'b0, rdy);
        chk("ns_ready_empty", {63'h0, rdy}, 64'd1);
        cyc(1, 1'b0, nil, 1'b0, 1'b0, 1'b0, rdy);
        chk("ns_ready_held", {63'h0, rdy}, 64'd0);
        cyc(1, 1'b1, mk(32'h7004, 32'h0000_0A02, 64'h72), 1'b1, 1'b0, 1'b0, rdy);
        chk("ns_ready_comb", {63'h0, rdy}, 64'd1);
        chk("ns_valid_stays", {63'h0, out_valid1}, 64'd1);
        chk("ns_replaced_pc", {32'h0, out_pc1}, 64'h7004);
        chk("ns_stall_cnt", {48'h0, stall1}, 64'd1);
        cyc(1, 1'b0, nil, 1'b1, 1'b0, 1'b0, rdy);
        chk("ns_drained", {63'h0, out_valid1}, 64'd0);

        chk("skid_pop_count", 64'(pops0), 64'd12);
        chk("noskid_pop_count", 64'(pops1), 64'd2);
        chk("skid_sb_empty", 64'(sb0.size()), 64'd0);
        chk("noskid_sb_empty", 64'(sb1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
